// File: rtl/projectile_pool.sv
// projectile_pool: multi-slot fixed-point projectile engine with fire handshake, per-frame motion and retirement.
//   clk, resetN       : system clock, asynchronous active-low reset
//   startOfFrame      : one-cycle pulse per video frame; advances every flying slot
//   fireReq           : fire request, held by the requester until fireAck
//   fireX, fireY      : signed start pixel, taken on the acknowledge cycle
//   fireVX, fireVY    : signed velocity in fixed-point units per frame
//   fireAck, fireSlot : one-cycle accept pulse and the slot index that was loaded
//   full              : every slot is flying
//   collision         : per-slot collision from the draw/collision logic
//   active            : per-slot live flag (draw enable)
//   topLeftX/Y        : packed per-slot pixel position, slot i at [i*COORD_W +: COORD_W]
//   projectileEnd     : per-slot one-cycle pulse when a slot retires
module projectile_pool #(
    parameter int NUM_SLOTS = 4,
    parameter int FRAC_BITS = 6,
    parameter int COORD_W = 11,
    parameter int VEL_W = 10,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479,
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          startOfFrame,
    input  logic                          fireReq,
    input  logic signed [COORD_W-1:0]     fireX,
    input  logic signed [COORD_W-1:0]     fireY,
    input  logic signed [VEL_W-1:0]       fireVX,
    input  logic signed [VEL_W-1:0]       fireVY,
    output logic                          fireAck,
    output logic [SLOT_W-1:0]             fireSlot,
    output logic                          full,
    input  logic [NUM_SLOTS-1:0]          collision,
    output logic [NUM_SLOTS-1:0]          active,
    output logic [NUM_SLOTS*COORD_W-1:0]  topLeftX,
    output logic [NUM_SLOTS*COORD_W-1:0]  topLeftY,
    output logic [NUM_SLOTS-1:0]          projectileEnd
);
    localparam int POS_W = COORD_W + FRAC_BITS + 1;
    localparam logic signed [POS_W:0] X_LIM = (POS_W + 1)'(X_MAX << FRAC_BITS);
    localparam logic signed [POS_W:0] Y_LIM = (POS_W + 1)'(Y_MAX << FRAC_BITS);

    typedef enum logic {IDLE, FLYING} state_t;

    state_t                  state_q [NUM_SLOTS];
    state_t                  state_d [NUM_SLOTS];
    logic signed [POS_W-1:0] pos_x [NUM_SLOTS];
    logic signed [POS_W-1:0] pos_y [NUM_SLOTS];
    logic signed [VEL_W-1:0] vel_x [NUM_SLOTS];
    logic signed [VEL_W-1:0] vel_y [NUM_SLOTS];
    // one extra bit so a step past either screen edge never wraps back into range
    logic signed [POS_W:0]   nxt_x [NUM_SLOTS];
    logic signed [POS_W:0]   nxt_y [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]    free;
    logic [NUM_SLOTS-1:0]    load;
    logic [NUM_SLOTS-1:0]    move;
    logic [NUM_SLOTS-1:0]    retire;
    logic [NUM_SLOTS-1:0]    off_screen;
    logic [SLOT_W-1:0]       sel;
    logic                    fire_go;
    logic signed [POS_W-1:0] fire_px;
    logic signed [POS_W-1:0] fire_py;

    assign fire_px = {fireX[COORD_W-1], fireX, {FRAC_BITS{1'b0}}};
    assign fire_py = {fireY[COORD_W-1], fireY, {FRAC_BITS{1'b0}}};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= IDLE;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= state_d[i];
        end
    end

    // Free set comes from the registered states, so a slot retiring this
    // cycle is not offered to a fire request until the next cycle.
    always_comb begin
        free = '0;
        sel = '0;
        off_screen = '0;
        retire = '0;
        move = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            free[i] = (state_q[i] == IDLE);
            if (free[i]) sel = SLOT_W'(i);
        end
        fire_go = fireReq && (|free);
        load = fire_go ? (free & ~(free - NUM_SLOTS'(1))) : '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            nxt_x[i] = {pos_x[i][POS_W-1], pos_x[i]} + {{(POS_W + 1 - VEL_W){vel_x[i][VEL_W-1]}}, vel_x[i]};
            nxt_y[i] = {pos_y[i][POS_W-1], pos_y[i]} + {{(POS_W + 1 - VEL_W){vel_y[i][VEL_W-1]}}, vel_y[i]};
            off_screen[i] = nxt_x[i][POS_W] || (nxt_x[i] > X_LIM) || nxt_y[i][POS_W] || (nxt_y[i] > Y_LIM);
            retire[i] = (state_q[i] == FLYING) && (collision[i] || (startOfFrame && off_screen[i]));
            move[i] = (state_q[i] == FLYING) && startOfFrame && !collision[i] && !off_screen[i];
            state_d[i] = load[i] ? FLYING : (retire[i] ? IDLE : state_q[i]);
        end
    end

    always_comb begin
        active = '0;
        topLeftX = '0;
        topLeftY = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            active[i] = (state_q[i] == FLYING);
            if (active[i]) begin
                topLeftX[i*COORD_W +: COORD_W] = pos_x[i][FRAC_BITS +: COORD_W];
                topLeftY[i*COORD_W +: COORD_W] = pos_y[i][FRAC_BITS +: COORD_W];
            end
        end
        full = &active;
    end

    // A slot loaded this cycle is IDLE in state_q, so it never moves on the
    // same frame pulse; a retiring slot keeps its last position.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fireAck <= 1'b0;
            fireSlot <= '0;
            projectileEnd <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
                vel_x[i] <= '0;
                vel_y[i] <= '0;
            end
        end else begin
            fireAck <= fire_go;
            if (fire_go) fireSlot <= sel;
            projectileEnd <= retire;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (load[i]) begin
                    pos_x[i] <= fire_px;
                    pos_y[i] <= fire_py;
                    vel_x[i] <= fireVX;
                    vel_y[i] <= fireVY;
                end else if (move[i]) begin
                    pos_x[i] <= nxt_x[i][POS_W-1:0];
                    pos_y[i] <= nxt_y[i][POS_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_projectile_pool.sv
// tb_projectile_pool: directed scenario tests for projectile_pool.
module tb_projectile_pool;
    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sof = 1'b0;
    logic fire_req = 1'b0;
    logic signed [10:0] fire_x = '0;
    logic signed [10:0] fire_y = '0;
    logic signed [9:0] fire_vx = '0;
    logic signed [9:0] fire_vy = '0;
    logic [3:0] collision = '0;
    logic fire_ack;
    logic [1:0] fire_slot;
    logic full;
    logic [3:0] active;
    logic [43:0] top_x;
    logic [43:0] top_y;
    logic [3:0] proj_end;
    int tests = 0;
    int fails = 0;

    projectile_pool dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .fireReq(fire_req),
        .fireX(fire_x), .fireY(fire_y), .fireVX(fire_vx), .fireVY(fire_vy),
        .fireAck(fire_ack), .fireSlot(fire_slot), .full(full), .collision(collision),
        .active(active), .topLeftX(top_x), .topLeftY(top_y), .projectileEnd(proj_end)
    );

    always #5 clk = ~clk;

    function automatic int tlx(int i);
        logic signed [10:0] v;
        v = top_x[i*11 +: 11];
        return int'(v);
    endfunction

    function automatic int tly(int i);
        logic signed [10:0] v;
        v = top_y[i*11 +: 11];
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 resetN = 1'b0;
        fire_req = 1'b0;
        sof = 1'b0;
        collision = '0;
        #13 resetN = 1'b1;
        tick();
    endtask

    task automatic fire(input int x, input int y, input int vx, input int vy);
        fire_x = 11'(x);
        fire_y = 11'(y);
        fire_vx = 10'(vx);
        fire_vy = 10'(vy);
        fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
    endtask

    task automatic frame();
        sof = 1'b1;
        tick();
        sof = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (active !== 4'b0000) begin fails++; $display("FAIL reset_active got %b exp 0000", active); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
        tests++; if (fire_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b exp 0", fire_ack); end
        tests++; if (fire_slot !== 2'd0) begin fails++; $display("FAIL reset_slot got %0d exp 0", fire_slot); end
        tests++; if (proj_end !== 4'b0000) begin fails++; $display("FAIL reset_end got %b exp 0000", proj_end); end
        tests++; if (top_x !== 44'd0 || top_y !== 44'd0) begin fails++; $display("FAIL reset_pos got %h/%h exp 0", top_x, top_y); end
    endtask

    task automatic test_basic_fire();
        do_reset();
        fire(100, 200, 0, -128);
        tests++; if (fire_ack !== 1'b1 || fire_slot !== 2'd0) begin fails++; $display("FAIL basic_ack got ack=%b slot=%0d exp ack=1 slot=0", fire_ack, fire_slot); end
        tests++; if (active !== 4'b0001) begin fails++; $display("FAIL basic_active got %b exp 0001", active); end
        tests++; if (tlx(0) != 100 || tly(0) != 200) begin fails++; $display("FAIL basic_start got (%0d,%0d) exp (100,200)", tlx(0), tly(0)); end
        for (int k = 1; k <= 3; k++) begin
            frame();
            tests++; if (tlx(0) != 100 || tly(0) != 200 - 2 * k) begin fails++; $display("FAIL basic_frame%0d got (%0d,%0d) exp (100,%0d)", k, tlx(0), tly(0), 200 - 2 * k); end
        end
        tests++; if (fire_ack !== 1'b0) begin fails++; $display("FAIL basic_ack_drop got %b exp 0", fire_ack); end
    endtask

    task automatic test_fractional();
        do_reset();
        fire(10, 10, 32, 96);
        frame();
        tests++; if (tlx(0) != 10 || tly(0) != 11) begin fails++; $display("FAIL frac_frame1 got (%0d,%0d) exp (10,11)", tlx(0), tly(0)); end
        frame();
        frame();
        frame();
        tests++; if (tlx(0) != 12 || tly(0) != 16) begin fails++; $display("FAIL frac_frame4 got (%0d,%0d) exp (12,16)", tlx(0), tly(0)); end
        tests++; if (active !== 4'b0001 || proj_end !== 4'b0000) begin fails++; $display("FAIL frac_alive got act=%b end=%b exp 0001/0000", active, proj_end); end
    endtask

    task automatic test_screen_exit();
        do_reset();
        fire(5, 2, 0, -64);
        frame();
        tests++; if (tly(0) != 1 || active !== 4'b0001) begin fails++; $display("FAIL exit_y1 got y=%0d act=%b exp 1/0001", tly(0), active); end
        frame();
        tests++; if (tly(0) != 0 || active !== 4'b0001) begin fails++; $display("FAIL exit_y0 got y=%0d act=%b exp 0/0001", tly(0), active); end
        frame();
        tests++; if (proj_end !== 4'b0001 || active !== 4'b0000) begin fails++; $display("FAIL exit_top got end=%b act=%b exp 0001/0000", proj_end, active); end
        tests++; if (tlx(0) != 0 || tly(0) != 0) begin fails++; $display("FAIL exit_idle_pos got (%0d,%0d) exp (0,0)", tlx(0), tly(0)); end
        tick();
        tests++; if (proj_end !== 4'b0000) begin fails++; $display("FAIL exit_end_drop got %b exp 0000", proj_end); end
        do_reset();
        fire(5, 479, 0, 64);
        frame();
        tests++; if (proj_end !== 4'b0001 || active !== 4'b0000) begin fails++; $display("FAIL exit_bottom got end=%b act=%b exp 0001/0000", proj_end, active); end
        do_reset();
        fire(638, 100, 64, 0);
        frame();
        tests++; if (tlx(0) != 639 || active !== 4'b0001) begin fails++; $display("FAIL exit_xmax_edge got x=%0d act=%b exp 639/0001", tlx(0), active); end
        frame();
        tests++; if (proj_end !== 4'b0001 || active !== 4'b0000) begin fails++; $display("FAIL exit_right got end=%b act=%b exp 0001/0000", proj_end, active); end
    endtask

    task automatic test_pool_full();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            fire(10 + 20 * k, 50, 0, 0);
            tests++; if (fire_ack !== 1'b1 || fire_slot !== 2'(k)) begin fails++; $display("FAIL full_alloc%0d got ack=%b slot=%0d exp 1/%0d", k, fire_ack, fire_slot, k); end
        end
        tests++; if (full !== 1'b1 || active !== 4'b1111) begin fails++; $display("FAIL full_flag got full=%b act=%b exp 1/1111", full, active); end
        fire_x = 11'd300;
        fire_y = 11'd40;
        fire_vx = '0;
        fire_vy = '0;
        fire_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests++; if (fire_ack !== 1'b0) begin fails++; $display("FAIL full_no_ack%0d got %b exp 0", k, fire_ack); end
        end
        collision = 4'b0100;
        tick();
        collision = '0;
        tests++; if (proj_end !== 4'b0100 || active !== 4'b1011 || fire_ack !== 1'b0) begin fails++; $display("FAIL full_retire got end=%b act=%b ack=%b exp 0100/1011/0", proj_end, active, fire_ack); end
        tick();
        fire_req = 1'b0;
        tests++; if (fire_ack !== 1'b1 || fire_slot !== 2'd2) begin fails++; $display("FAIL full_reuse got ack=%b slot=%0d exp 1/2", fire_ack, fire_slot); end
        tests++; if (active !== 4'b1111 || tlx(2) != 300 || tly(2) != 40) begin fails++; $display("FAIL full_reuse_pos got act=%b (%0d,%0d) exp 1111 (300,40)", active, tlx(2), tly(2)); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fire(100, 100, 0, 64);
        fire(200, 100, 0, 64);
        fire(300, 100, 0, 64);
        collision = 4'b0010;
        sof = 1'b1;
        tick();
        collision = '0;
        sof = 1'b0;
        tests++; if (proj_end !== 4'b0010 || active !== 4'b0101) begin fails++; $display("FAIL sim_coll got end=%b act=%b exp 0010/0101", proj_end, active); end
        tests++; if (tly(0) != 101 || tly(2) != 101 || tly(1) != 0) begin fails++; $display("FAIL sim_coll_pos got y0=%0d y1=%0d y2=%0d exp 101/0/101", tly(0), tly(1), tly(2)); end
        fire_x = 11'd50;
        fire_y = 11'd60;
        fire_vx = 10'd64;
        fire_vy = 10'd64;
        fire_req = 1'b1;
        sof = 1'b1;
        tick();
        fire_req = 1'b0;
        sof = 1'b0;
        tests++; if (fire_ack !== 1'b1 || fire_slot !== 2'd1) begin fails++; $display("FAIL sim_fire_sof_ack got ack=%b slot=%0d exp 1/1", fire_ack, fire_slot); end
        tests++; if (tlx(1) != 50 || tly(1) != 60 || tly(0) != 102) begin fails++; $display("FAIL sim_fire_sof_pos got (%0d,%0d) y0=%0d exp (50,60) 102", tlx(1), tly(1), tly(0)); end
        frame();
        tests++; if (tlx(1) != 51 || tly(1) != 61) begin fails++; $display("FAIL sim_next_frame got (%0d,%0d) exp (51,61)", tlx(1), tly(1)); end
        collision = 4'b0001;
        fire_x = 11'd400;
        fire_y = 11'd300;
        fire_vx = '0;
        fire_vy = '0;
        fire_req = 1'b1;
        tick();
        collision = '0;
        fire_req = 1'b0;
        tests++; if (fire_slot !== 2'd3 || proj_end !== 4'b0001 || active !== 4'b1110) begin fails++; $display("FAIL sim_fire_retire got slot=%0d end=%b act=%b exp 3/0001/1110", fire_slot, proj_end, active); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        fire(100, 100, 0, 64);
        fire(200, 100, 0, 64);
        fire(300, 100, 0, 64);
        @(posedge clk);
        #3 resetN = 1'b0;
        #1;
        tests++; if (active !== 4'b0000 || fire_ack !== 1'b0 || full !== 1'b0) begin fails++; $display("FAIL rstmid_async got act=%b ack=%b full=%b exp 0000/0/0", active, fire_ack, full); end
        tests++; if (top_x !== 44'd0 || top_y !== 44'd0) begin fails++; $display("FAIL rstmid_pos got %h/%h exp 0", top_x, top_y); end
        #3 resetN = 1'b1;
        tick();
        tests++; if (proj_end !== 4'b0000 || active !== 4'b0000) begin fails++; $display("FAIL rstmid_no_end got end=%b act=%b exp 0000/0000", proj_end, active); end
        fire(20, 30, 0, 0);
        tests++; if (fire_ack !== 1'b1 || fire_slot !== 2'd0 || active !== 4'b0001) begin fails++; $display("FAIL rstmid_refire got ack=%b slot=%0d act=%b exp 1/0/0001", fire_ack, fire_slot, active); end
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_fractional();
        test_screen_exit();
        test_pool_full();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
